// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, instruction width, bubble word, PC step.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Next-PC priority mux: branch > jump > stall-hold > PC+4, word-aligned, wrapping mod 2^PC_W.
// Latency: purely combinational.
// Backpressure: stall only holds the PC when no redirect is present.
module next_pc_sel
  import mips_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            jump_i,
  input  logic [PC_W-3:0] jump_index_i,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic [PC_W-1:0] next_pc_o
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  // Branch target low bits are dropped by alignment; collect them so they are not flagged.
  logic unused_bt_lsb;
  assign unused_bt_lsb = ^branch_target_i[1:0];

  // Priority select: the branch belongs to the older instruction, so it beats the jump.
  always_comb begin
    pc_plus4_o = pc_i + STEP;
    if (branch_taken_i) begin
      next_pc_o = {branch_target_i[PC_W-1:2], 2'b00};
    end else if (jump_i) begin
      next_pc_o = {jump_index_i, 2'b00};
    end else if (stall_i) begin
      next_pc_o = pc_i;
    end else begin
      next_pc_o = pc_plus4_o;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IM word address, IF/ID register, BOOT/RUN/HALT gating.
// Latency: instruction at PC=A appears on if_id_* one edge later; first fetch two edges after reset.
// Backpressure: stall holds PC and IF/ID; flush/redirect insert a bubble. FETCH_STATS_EN adds counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              IM_AW    = 6,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               jump,
  input  logic [PC_W-3:0]    jump_index,
  input  logic               halt_req,
  output logic [IM_AW-1:0]   im_addr,
  input  logic [INSTR_W-1:0] im_instr,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc4,
  output logic               if_id_valid,
`ifdef FETCH_STATS_EN
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count,
`endif
  output logic               halted
);

  fetch_state_t state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_plus4, pc_sel;
  logic               run_en, redirect, kill, load;

  next_pc_sel #(.PC_W(PC_W)) u_next_pc_sel (
    .pc_i            (pc_q),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_index_i    (jump_index),
    .pc_plus4_o      (pc_plus4),
    .next_pc_o       (pc_sel)
  );

  assign im_addr  = pc_q[PC_W-1:2];
  assign redirect = branch_taken | jump;
  assign kill     = flush | redirect;
  assign load     = run_en & ~kill & ~stall;

  // FSM state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // FSM next state: one BOOT cycle, RUN until halt_req, HALT until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt_req) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // FSM outputs: fetch enable and halted flag.
  always_comb begin
    run_en = 1'b0;
    halted = 1'b0;
    case (state_q)
      RUN:     run_en = 1'b1;
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  // Next-state for PC and IF/ID; im_instr is only looked at on a real load.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (run_en) begin
      pc_d = pc_sel;
      if (kill) begin
        instr_d = NOP_INSTR;
        pc4_d   = '0;
        valid_d = 1'b0;
      end else if (!stall) begin
        instr_d = im_instr;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end else if (state_q == HALT) begin
      valid_d = 1'b0;
    end
  end

  // PC and IF/ID registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        stall_evt;

  assign stall_evt = run_en & stall & ~redirect;

  // Saturating fetch/stall counters; they only move in RUN, so HALT freezes them.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_evt && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for the main flow plus a mid-HALT reset sequence.
// Memory model returns 32'h1000_0000 + word address combinationally.
// Inputs driven on the falling edge, outputs compared on the next falling edge.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        stall, flush, branch_taken, jump, halt_req;
  logic [7:0]  branch_target;
  logic [5:0]  jump_index;
  logic [5:0]  im_addr;
  logic [31:0] im_instr;
  logic [31:0] if_id_instr;
  logic [7:0]  if_id_pc4;
  logic        if_id_valid;
  logic        halted;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign im_instr = 32'h1000_0000 + {26'd0, im_addr};

  fetch_stage #(.PC_W(8), .IM_AW(6), .RESET_PC(8'h00)) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .halt_req      (halt_req),
    .im_addr       (im_addr),
    .im_instr      (im_instr),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
`ifdef FETCH_STATS_EN
    .fetch_count   (fetch_count),
    .stall_count   (stall_count),
`endif
    .halted        (halted)
  );

  typedef struct {
    logic        st, fl, br;
    logic [7:0]  bt;
    logic        jp;
    logic [5:0]  ji;
    logic        hr;
    logic [7:0]  e_pc;
    logic        e_vld;
    logic [31:0] e_ins;
    logic [7:0]  e_pc4;
    logic        e_hlt;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  function automatic vec_t mk(logic st, logic fl, logic br, logic [7:0] bt, logic jp,
                              logic [5:0] ji, logic hr, logic [7:0] e_pc, logic e_vld,
                              logic [31:0] e_ins, logic [7:0] e_pc4, logic e_hlt);
    vec_t v;
    v.st = st; v.fl = fl; v.br = br; v.bt = bt; v.jp = jp; v.ji = ji; v.hr = hr;
    v.e_pc = e_pc; v.e_vld = e_vld; v.e_ins = e_ins; v.e_pc4 = e_pc4; v.e_hlt = e_hlt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_pc, input logic e_vld,
                         input logic [31:0] e_ins, input logic [7:0] e_pc4, input logic e_hlt);
    chk({tag, ".im_addr"}, {26'd0, im_addr}, {26'd0, e_pc[7:2]});
    chk({tag, ".valid"},   {31'd0, if_id_valid}, {31'd0, e_vld});
    chk({tag, ".instr"},   if_id_instr, e_ins);
    chk({tag, ".pc4"},     {24'd0, if_id_pc4}, {24'd0, e_pc4});
    chk({tag, ".halted"},  {31'd0, halted}, {31'd0, e_hlt});
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; branch_taken = 0; branch_target = 8'h00;
    jump = 0; jump_index = 6'd0; halt_req = 0;
  endtask

  localparam logic [31:0] W = 32'h1000_0000;

  initial begin
    //                st fl br bt     jp ji     hr  pc     v  instr      pc4    h
    vecs[0]  = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h00, 0, 32'h0,     8'h00, 0); // BOOT edge
    vecs[1]  = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h04, 1, W + 0,     8'h04, 0);
    vecs[2]  = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h08, 1, W + 1,     8'h08, 0);
    vecs[3]  = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h0C, 1, W + 2,     8'h0C, 0);
    vecs[4]  = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h10, 1, W + 3,     8'h10, 0);
    vecs[5]  = mk(1, 0, 0, 8'h00, 0, 6'd0,  0, 8'h10, 1, W + 3,     8'h10, 0); // stall x3 at PC=16
    vecs[6]  = mk(1, 0, 0, 8'h00, 0, 6'd0,  0, 8'h10, 1, W + 3,     8'h10, 0);
    vecs[7]  = mk(1, 0, 0, 8'h00, 0, 6'd0,  0, 8'h10, 1, W + 3,     8'h10, 0);
    vecs[8]  = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h14, 1, W + 4,     8'h14, 0);
    vecs[9]  = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h18, 1, W + 5,     8'h18, 0);
    vecs[10] = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h1C, 1, W + 6,     8'h1C, 0);
    vecs[11] = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h20, 1, W + 7,     8'h20, 0);
    vecs[12] = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h24, 1, W + 8,     8'h24, 0);
    vecs[13] = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h28, 1, W + 9,     8'h28, 0);
    vecs[14] = mk(0, 0, 1, 8'h83, 1, 6'd5,  0, 8'h80, 0, 32'h0,     8'h00, 0); // branch beats jump
    vecs[15] = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h84, 1, W + 32,    8'h84, 0);
    vecs[16] = mk(0, 0, 0, 8'h00, 1, 6'd62, 0, 8'hF8, 0, 32'h0,     8'h00, 0);
    vecs[17] = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'hFC, 1, W + 62,    8'hFC, 0);
    vecs[18] = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h00, 1, W + 63,    8'h00, 0); // wrap
    vecs[19] = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h04, 1, W + 0,     8'h04, 0);
    vecs[20] = mk(1, 1, 0, 8'h00, 0, 6'd0,  0, 8'h04, 0, 32'h0,     8'h00, 0); // stall+flush
    vecs[21] = mk(1, 0, 0, 8'h00, 1, 6'd2,  0, 8'h08, 0, 32'h0,     8'h00, 0); // jump overrides stall
    vecs[22] = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h0C, 1, W + 2,     8'h0C, 0);
    vecs[23] = mk(0, 1, 0, 8'h00, 0, 6'd0,  0, 8'h10, 0, 32'h0,     8'h00, 0); // flush alone
    vecs[24] = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h14, 1, W + 4,     8'h14, 0);
    vecs[25] = mk(0, 0, 0, 8'h00, 0, 6'd0,  1, 8'h18, 1, W + 5,     8'h18, 1); // halt at PC=20
    vecs[26] = mk(0, 0, 0, 8'h00, 0, 6'd0,  0, 8'h18, 0, W + 5,     8'h18, 1);
    vecs[27] = mk(0, 0, 1, 8'h40, 1, 6'd9,  0, 8'h18, 0, W + 5,     8'h18, 1); // HALT ignores redirect

    idle_inputs();
    RSTn = 1'b0;
    #12;
    chk_all("reset", 8'h00, 1'b0, 32'h0, 8'h00, 1'b0);

    @(negedge CLK);
    RSTn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      stall = vecs[i].st; flush = vecs[i].fl; branch_taken = vecs[i].br;
      branch_target = vecs[i].bt; jump = vecs[i].jp; jump_index = vecs[i].ji;
      halt_req = vecs[i].hr;
      @(posedge CLK);
      @(negedge CLK);
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_vld, vecs[i].e_ins,
              vecs[i].e_pc4, vecs[i].e_hlt);
    end

`ifdef FETCH_STATS_EN
    chk("fetch_count", fetch_count, 32'd17);
    chk("stall_count", stall_count, 32'd4);
`endif

    // Asynchronous reset in the middle of HALT, then restart from RESET_PC.
    idle_inputs();
    #2;
    RSTn = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 1'b0, 32'h0, 8'h00, 1'b0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk_all("reboot", 8'h00, 1'b0, 32'h0, 8'h00, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    chk_all("refetch", 8'h04, 1'b1, W + 0, 8'h04, 1'b0);
`ifdef FETCH_STATS_EN
    chk("fetch_count_rst", fetch_count, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage feeding the 64x32 instruction memory and the decode stage. It owns the program counter and next-PC selection (sequential, branch, jump), drives the instruction-memory word address, and registers the returned instruction into an IF/ID pipeline register with valid, stall and flush control. A small boot/run/halt FSM gates fetching.

Parameters:
PC_W, 8, program-counter width in bits (byte address).
IM_AW, 6, instruction-memory word-address width; must equal PC_W-2.
RESET_PC, 8'h00, byte address loaded into PC at reset; low 2 bits must be 0.

Ports:
CLK  in  1  system clock, all state updates on rising edge
RSTn  in  1  asynchronous active-low reset
stall  in  1  decode hazard; hold PC and IF/ID contents
flush  in  1  kill the instruction currently entering IF/ID (insert bubble)
branch_taken  in  1  redirect PC to branch_target
branch_target  in  PC_W  branch byte address
jump  in  1  redirect PC to jump target
jump_index  in  PC_W-2  word index of jump target
halt_req  in  1  stop fetching after the current edge
im_addr  out  IM_AW  word address to instruction memory
im_instr  in  32  instruction returned by memory (combinational read)
if_id_instr  out  32  registered instruction
if_id_pc4  out  PC_W  registered PC+4 of that instruction
if_id_valid  out  1  IF/ID holds a real instruction
halted  out  1  FSM is in HALT

Behaviour:
- Clock and reset: single clock CLK; reset RSTn is asynchronous and active-low.
- Reset (RSTn=0, immediate): PC=RESET_PC, state=BOOT, if_id_instr=0, if_id_pc4=0, if_id_valid=0, halted=0.
- im_addr = PC[PC_W-1:2], combinational; the memory returns im_instr in the same cycle.
- FSM states:
  - BOOT: exactly one cycle after reset release; no PC update, if_id_valid stays 0 → RUN.
  - RUN: normal fetch.
  - HALT: PC and IF/ID frozen, if_id_valid=0, halted=1. Exit only through reset.
- RUN → HALT on any edge with halt_req=1. The instruction fetched on that edge is still captured, subject to stall/flush; the following edge clears valid.
- Next PC in RUN, priority high→low:
  - branch_taken: {branch_target[PC_W-1:2],2'b00}; low bits forced to 0.
  - jump: {jump_index,2'b00}.
  - stall: PC held.
  - otherwise: PC+4, modulo 2^PC_W. 252+4 wraps to 0.
- Branch beats jump: the branch comes from the older instruction. A redirect overrides stall.
- IF/ID update in RUN, priority high→low:
  - flush or branch_taken or jump: if_id_valid←0, instr←0, pc4←0.
  - stall: all IF/ID fields held.
  - otherwise: instr←im_instr, pc4←PC+4 (wrapped), valid←1.
- Latency: instruction at address A appears on if_id_* one edge after PC=A.
- Reset asserted mid-operation overrides everything asynchronously; the first valid fetch after release is RESET_PC, two edges after release.
- No X propagation: im_instr is sampled only when the IF/ID load condition holds.

Optional Feature:
FETCH_STATS_EN
- Defined: adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on each edge where if_id_valid is loaded with 1.
  - stall_count increments on each RUN edge with stall=1 and no redirect.
  - Both saturate at 32'hFFFF_FFFF and freeze in HALT.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - fetch_state_t enum {BOOT, RUN, HALT}
  - INSTR_W=32
  - NOP_INSTR=32'h0
  - PC_STEP=4
- Natural sub-module next_pc_sel: pure combinational next-PC priority mux (branch/jump/stall/increment, wrap and alignment). The PC register, IF/ID register and FSM stay in fetch_stage.

Test Plan:
1. Reset release, no stall, memory word k = 32'h1000_0000+k → cycle1 BOOT valid=0; then if_id_instr 32'h1000_0000, 32'h1000_0001…; pc4 = 4, 8, …
2. Run to PC=252 → instr word 63 with pc4=0; the next fetch is word 0 (wrap).
3. stall=1 for 3 cycles at PC=16 → PC stays 16; IF/ID holds the word-3 instruction; PC=20 fetch resumes after release.
4. At PC=40, assert branch_taken=1, branch_target=8'h83 and jump=1, jump_index=5 together → PC=8'h80 (branch wins, alignment); if_id_valid=0 for one cycle.
5. stall=1 and flush=1 together → IF/ID becomes bubble (valid=0) and PC held. stall=1 and jump=1 with jump_index=2 → PC=8.
6. halt_req pulse at PC=20 → word 5 captured, then valid=0, halted=1, PC frozen at 24. RSTn low mid-HALT → immediate reset values; restart from RESET_PC.
